// File: rtl/controle_bomba.sv
`default_nettype none
// ============================================================================
// Module   : controle_bomba
// Purpose  : Shares the single irrigation pump between the water request and
//            the pesticide (agro) dosing request. Grants one source at a
//            time, alternating on ties, with a minimum water run time, a
//            committed fixed-length dose and a purge interval after every
//            grant. The user button aborts an active grant.
// Ports    : clockPlaca  - board clock, rising edge
//            reset       - asynchronous active-high reset, forces idle
//            tick1s      - one-clock pulse once per second (time base)
//            reqAgua     - water request (level)
//            reqAgro     - pesticide request (level)
//            tanqueVazio - water tank empty (level)
//            abortar     - debounced button, one-clock pulse
//            bomba       - pump on
//            valvAgua    - water valve open
//            valvAgro    - pesticide valve open
//            fase        - state code (00 idle, 01 water, 10 agro, 11 purge)
//            tempo       - remaining ticks in current phase
//            doseOk      - one-clock pulse after a completed dose
// Revision : 1.0 - initial release
// ============================================================================
module controle_bomba #(
  parameter int MIN_AGUA  = 5,
  parameter int DOSE_AGRO = 10,
  parameter int PURGA     = 3
) (
  input  logic       clockPlaca,
  input  logic       reset,
  input  logic       tick1s,
  input  logic       reqAgua,
  input  logic       reqAgro,
  input  logic       tanqueVazio,
  input  logic       abortar,
  output logic       bomba,
  output logic       valvAgua,
  output logic       valvAgro,
  output logic [1:0] fase,
  output logic [5:0] tempo,
  output logic       doseOk
);

  localparam logic [1:0] OCIOSO   = 2'b00;
  localparam logic [1:0] AGUA     = 2'b01;
  localparam logic [1:0] AGRO     = 2'b10;
  localparam logic [1:0] PURGA_ST = 2'b11;

  // Last granted source, used to alternate when both requests are pending.
  localparam logic ULT_AGUA = 1'b0;
  localparam logic ULT_AGRO = 1'b1;

  localparam logic [5:0] C_MIN_AGUA  = 6'(MIN_AGUA);
  localparam logic [5:0] C_DOSE_AGRO = 6'(DOSE_AGRO);
  localparam logic [5:0] C_PURGA     = 6'(PURGA);

  logic [1:0] state_q,   state_d;
  logic [5:0] tempo_q,   tempo_d;
  logic       ultimo_q,  ultimo_d;
  logic       flush_q,   flush_d;
  logic       dose_ok_q, dose_ok_d;

  logic cand_agua;
  logic cand_agro;

  assign cand_agua = reqAgua && !tanqueVazio;
  assign cand_agro = reqAgro;

  always_comb begin
    state_d   = state_q;
    ultimo_d  = ultimo_q;
    flush_d   = flush_q;
    dose_ok_d = 1'b0;
    // Default: saturating countdown; any load below overrides it, so a tick
    // on a load edge is deliberately lost.
    if (tick1s && (tempo_q != 6'd0)) begin
      tempo_d = tempo_q - 6'd1;
    end else begin
      tempo_d = tempo_q;
    end

    case (state_q)
      OCIOSO: begin
        tempo_d = 6'd0;
        if (cand_agua && (!cand_agro || (ultimo_q == ULT_AGRO))) begin
          state_d  = AGUA;
          tempo_d  = C_MIN_AGUA;
          ultimo_d = ULT_AGUA;
        end else if (cand_agro) begin
          state_d  = AGRO;
          tempo_d  = C_DOSE_AGRO;
          ultimo_d = ULT_AGRO;
        end
      end

      AGUA: begin
        // An empty tank cuts water at once, independent of the minimum time.
        if (tanqueVazio || abortar || ((tempo_q == 6'd0) && !reqAgua)) begin
          state_d = PURGA_ST;
          tempo_d = C_PURGA;
          flush_d = 1'b0;
        end
      end

      AGRO: begin
        // The dose is committed: reqAgro and tanqueVazio are not looked at.
        // An abort on the final edge still counts as aborted (no doseOk).
        if (abortar) begin
          state_d = PURGA_ST;
          tempo_d = C_PURGA;
          flush_d = !tanqueVazio;
        end else if (tempo_q == 6'd0) begin
          state_d   = PURGA_ST;
          tempo_d   = C_PURGA;
          flush_d   = !tanqueVazio;
          dose_ok_d = 1'b1;
        end
      end

      default: begin  // PURGA_ST: abortar has no effect here
        if (tanqueVazio) begin
          flush_d = 1'b0;
        end
        if (tempo_q == 6'd0) begin
          state_d = OCIOSO;
          tempo_d = 6'd0;
          flush_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clockPlaca or posedge reset) begin
    if (reset) begin
      state_q   <= OCIOSO;
      tempo_q   <= 6'd0;
      ultimo_q  <= ULT_AGRO;
      flush_q   <= 1'b0;
      dose_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tempo_q   <= tempo_d;
      ultimo_q  <= ultimo_d;
      flush_q   <= flush_d;
      dose_ok_q <= dose_ok_d;
    end
  end

  // Outputs decode only registered state, so no input reaches an output
  // combinationally. The flush flag is only ever set in PURGA_ST, and the two
  // valve terms are state-exclusive.
  always_comb begin
    fase     = state_q;
    tempo    = tempo_q;
    doseOk   = dose_ok_q;
    valvAgro = (state_q == AGRO);
    valvAgua = (state_q == AGUA) || ((state_q == PURGA_ST) && flush_q);
    bomba    = (state_q == AGUA) || (state_q == AGRO) ||
               ((state_q == PURGA_ST) && flush_q);
  end

endmodule
`default_nettype wire
